mass_bin_sorter: RTL and testbench
==================================

Name: mass_bin_sorter

Overview:
Parametrised mass classifier with programmable bin thresholds. Each valid mass sample is sorted into one of NUM_BINS contiguous weight bins, or rejected if out of range. Per-bin and reject tallies are kept in saturating counters. Sits after the mass-estimation stage and drives sorting gates and batch-statistics readout.

Parameters:
DATA_W, 10, width of mass sample and thresholds
NUM_BINS, 3, number of output bins (>=1)
CNT_W, 16, width of each per-bin counter
THR_INIT, {10'd450,10'd400,10'd340,10'd240}, reset thresholds, (NUM_BINS+1)*DATA_W bits, boundary k in bits [k*DATA_W +: DATA_W]

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
data  in  DATA_W  mass sample
data_valid  in  1  sample qualifier
thr_wr  in  1  threshold write strobe
thr_idx  in  clog2(NUM_BINS+1)  boundary index to write
thr_data  in  DATA_W  boundary value
cnt_clear  in  1  synchronous clear of all counters
rd_idx  in  clog2(NUM_BINS+1)  counter select (NUM_BINS selects reject counter)
rd_data  out  CNT_W  selected counter value
out_valid  out  1  classification result valid
out_choise  out  NUM_BINS  one-hot bin result
out_reject  out  1  sample outside all bins

Behaviour:
- Clock clk; reset is asynchronous and active-high.
- Reset: thresholds <- THR_INIT, all counters 0, out_valid 0, out_choise 0, out_reject 0, rd_data 0, pipeline valids 0.
- Bin rule, boundaries t0..tNUM_BINS: bin 0 matches t0 <= data <= t1. Bin k>0 matches t_k < data <= t_(k+1). All compares unsigned.
- Non-monotonic thresholds are not checked. On multiple matches the lowest index wins, so out_choise is always one-hot or zero.
- Reject: no bin matches (data < t0 or data > tNUM_BINS) -> out_reject 1, out_choise 0.
- Pipeline: stage 1 registers the per-bin compare vector and valid. Stage 2 does priority encoding, registers the outputs and increments the counter.
- Latency is 2 cycles from a data_valid sample to out_valid. Throughput is one sample per cycle. No backpressure.
- When out_valid=0, out_choise and out_reject are held at 0.
- Threshold write: thr_wr=1 updates boundary thr_idx at the clock edge. A sample accepted in that same cycle uses the old values; the next cycle's sample uses the new ones.
- thr_idx > NUM_BINS is ignored. Write is ignored during reset.
- Counters: NUM_BINS+1 counters (bins plus reject), CNT_W bits each. Increment on stage-2 valid. Saturate at 2^CNT_W-1, no wrap.
- cnt_clear zeroes all counters. If clear and an increment happen in the same cycle, clear wins and that sample is not counted.
- Readout: rd_data registered one cycle after rd_idx. rd_idx > NUM_BINS returns 0.
- Reset mid-stream drops in-flight samples and does not produce out_valid for them.

Decomposition:
- Shared package: default boundary constants (240, 340, 400, 450), the index width function clog2, and the counter max constant.
- One sub-module, mass_bin_counter: a saturating counter with increment and clear, clear-priority. Instantiated NUM_BINS+1 times.

Test Plan:
- Default thresholds; samples 240, 340, 341, 400, 450, 239, 451 -> out_choise 001, 001, 010, 010, 100, reject, reject, each 2 cycles after input.
- Back-to-back 1000 valid samples with data=300 -> out_valid continuous; rd_idx=0 gives 1000; other counters read 0.
- Write boundary 1 to 300 via thr_wr, then send data=300 the next cycle -> bin 0. Send data=300 in the same cycle as the write -> old rules, still bin 0. Then send data=301 -> bin 1.
- CNT_W=4; 20 samples into bin 2 -> counter saturates at 15. Apply cnt_clear in the same cycle as a bin-2 out_valid -> counter reads 0.
- Assert reset with two samples in flight -> out_valid stays 0, counters 0, thresholds back to THR_INIT.
- NUM_BINS=5 with thresholds 0, 10, 20, 30, 40, 50 loaded; sweep data 0..60 -> bin counts 11, 10, 10, 10, 10 and reject 10.

Source files
------------

// File: rtl/mass_bin_sorter_pkg.sv
// Shared definitions for the mass bin sorter: default parameter values,
// the reset boundary set for the three-bin configuration, the index-width
// helper and the all-ones pattern the saturating counters compare against.
package mass_bin_sorter_pkg;

    localparam int DATA_W_DEF   = 10;
    localparam int NUM_BINS_DEF = 3;
    localparam int CNT_W_DEF    = 16;

    localparam logic [9:0] BND0_DEF = 10'd240;
    localparam logic [9:0] BND1_DEF = 10'd340;
    localparam logic [9:0] BND2_DEF = 10'd400;
    localparam logic [9:0] BND3_DEF = 10'd450;

    // Truncated to CNT_W to get the saturation value of any counter width.
    localparam logic [63:0] CNT_ALL_ONES = '1;

    // Bits needed to index n items; never less than 1.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mass_bin_counter.sv
// Saturating tally counter with synchronous clear. Clear beats increment.
// Ports: clk, reset (async, active-high), inc_i (count one), clr_i (zero),
// cnt_o (current count).
module mass_bin_counter
    import mass_bin_sorter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_ALL_ONES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mass_bin_sorter.sv
// Mass classifier: sorts each valid sample into one of NUM_BINS contiguous
// bins bounded by programmable thresholds, or rejects it, and keeps a
// saturating tally per bin plus one for rejects.
// Ports: clk, reset (async, active-high); data/data_valid sample input;
// thr_wr/thr_idx/thr_data boundary write; cnt_clear zeroes all tallies;
// rd_idx/rd_data registered tally readout (index NUM_BINS = rejects);
// out_valid/out_choise/out_reject classification result, 2 cycles after input.
module mass_bin_sorter
    import mass_bin_sorter_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_BINS = NUM_BINS_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter logic [(NUM_BINS+1)*DATA_W-1:0] THR_INIT =
        {BND3_DEF, BND2_DEF, BND1_DEF, BND0_DEF},
    localparam int IDX_W = clog2(NUM_BINS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   data,
    input  logic                data_valid,
    input  logic                thr_wr,
    input  logic [IDX_W-1:0]    thr_idx,
    input  logic [DATA_W-1:0]   thr_data,
    input  logic                cnt_clear,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [CNT_W-1:0]    rd_data,
    output logic                out_valid,
    output logic [NUM_BINS-1:0] out_choise,
    output logic                out_reject
);

    localparam int TW = (NUM_BINS + 1) * DATA_W;

    logic [TW-1:0]       thr_q, thr_d;
    logic [NUM_BINS-1:0] match_q, match_d;
    logic                vld_q;
    logic [NUM_BINS-1:0] first_hit;
    logic                out_valid_q;
    logic [NUM_BINS-1:0] choise_q, choise_d;
    logic                reject_q, reject_d;
    logic [NUM_BINS:0]   inc;
    logic [CNT_W-1:0]    cnt [NUM_BINS+1];
    logic [CNT_W-1:0]    rd_data_q, rd_data_d;

    // Indices above NUM_BINS match no slot, so such writes fall away.
    always_comb begin
        thr_d = thr_q;
        for (int k = 0; k <= NUM_BINS; k++) begin
            if (thr_wr && (thr_idx == IDX_W'(k))) begin
                thr_d[k*DATA_W +: DATA_W] = thr_data;
            end
        end
    end

    // Bin 0 is closed at its lower edge; the others are open below so that a
    // value sitting exactly on a shared boundary lands in the lower bin.
    always_comb begin
        match_d = '0;
        for (int k = 0; k < NUM_BINS; k++) begin
            if (k == 0) begin
                match_d[k] = (data >= thr_q[0 +: DATA_W]) &&
                             (data <= thr_q[DATA_W +: DATA_W]);
            end else begin
                match_d[k] = (data >  thr_q[k*DATA_W +: DATA_W]) &&
                             (data <= thr_q[(k+1)*DATA_W +: DATA_W]);
            end
        end
    end

    // Isolate the lowest set bit: overlapping bins from non-monotonic
    // thresholds resolve to the lowest index.
    assign first_hit = match_q & (~match_q + NUM_BINS'(1));

    always_comb begin
        choise_d = vld_q ? first_hit : '0;
        reject_d = vld_q && (match_q == '0);
    end

    assign inc = {reject_d, choise_d};

    for (genvar k = 0; k <= NUM_BINS; k++) begin : g_cnt
        mass_bin_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc_i (inc[k]),
            .clr_i (cnt_clear),
            .cnt_o (cnt[k])
        );
    end

    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k <= NUM_BINS; k++) begin
            if (rd_idx == IDX_W'(k)) begin
                rd_data_d = cnt[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thr_q       <= THR_INIT;
            match_q     <= '0;
            vld_q       <= 1'b0;
            out_valid_q <= 1'b0;
            choise_q    <= '0;
            reject_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            thr_q       <= thr_d;
            match_q     <= match_d;
            vld_q       <= data_valid;
            out_valid_q <= vld_q;
            choise_q    <= choise_d;
            reject_q    <= reject_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_choise = choise_q;
    assign out_reject = reject_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_mass_bin_sorter.sv
module tb_mass_bin_sorter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        logic [4:0] ch;
        logic       rj;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [9:0] d;
        logic [2:0] ch;
        logic       rj;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    vec_t vecs[10];

    // instance A: default configuration
    logic        rst_a;
    logic [9:0]  a_data;
    logic        a_valid, a_thr_wr, a_clr;
    logic [1:0]  a_thr_idx, a_rd_idx;
    logic [9:0]  a_thr_data;
    logic [15:0] a_rd_data;
    logic        a_ov, a_rj;
    logic [2:0]  a_ch;

    // instance B: five bins, 4-bit counters
    logic        rst_b;
    logic [9:0]  b_data;
    logic        b_valid, b_thr_wr, b_clr;
    logic [2:0]  b_thr_idx, b_rd_idx;
    logic [9:0]  b_thr_data;
    logic [3:0]  b_rd_data;
    logic        b_ov, b_rj;
    logic [4:0]  b_ch;

    mass_bin_sorter u_a (
        .clk        (clk),
        .reset      (rst_a),
        .data       (a_data),
        .data_valid (a_valid),
        .thr_wr     (a_thr_wr),
        .thr_idx    (a_thr_idx),
        .thr_data   (a_thr_data),
        .cnt_clear  (a_clr),
        .rd_idx     (a_rd_idx),
        .rd_data    (a_rd_data),
        .out_valid  (a_ov),
        .out_choise (a_ch),
        .out_reject (a_rj)
    );

    mass_bin_sorter #(
        .NUM_BINS (5),
        .CNT_W    (4),
        .THR_INIT ({10'd500, 10'd400, 10'd300, 10'd200, 10'd100, 10'd0})
    ) u_b (
        .clk        (clk),
        .reset      (rst_b),
        .data       (b_data),
        .data_valid (b_valid),
        .thr_wr     (b_thr_wr),
        .thr_idx    (b_thr_idx),
        .thr_data   (b_thr_data),
        .cnt_clear  (b_clr),
        .rd_idx     (b_rd_idx),
        .rd_data    (b_rd_data),
        .out_valid  (b_ov),
        .out_choise (b_ch),
        .out_reject (b_rj)
    );

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        n_tot++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // scoreboard monitors: one result expected exactly 2 cycles after each sample
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0 && qa[0].cyc < cyc) begin
            chk(1'b0, "a_missing_result", 0, 1);
            void'(qa.pop_front());
        end
        if (a_ov) begin
            if (qa.size() == 0) begin
                chk(1'b0, "a_unexpected_valid", 1, 0);
            end else begin
                e = qa.pop_front();
                chk(a_ch == e.ch[2:0] && a_rj == e.rj, "a_result", {a_ch, a_rj}, {e.ch[2:0], e.rj});
                chk(cyc == e.cyc, "a_latency", cyc, e.cyc);
            end
        end else begin
            chk(a_ch == 3'b000 && !a_rj, "a_idle_zero", {a_ch, a_rj}, 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (qb.size() > 0 && qb[0].cyc < cyc) begin
            chk(1'b0, "b_missing_result", 0, 1);
            void'(qb.pop_front());
        end
        if (b_ov) begin
            if (qb.size() == 0) begin
                chk(1'b0, "b_unexpected_valid", 1, 0);
            end else begin
                e = qb.pop_front();
                chk(b_ch == e.ch && b_rj == e.rj, "b_result", {b_ch, b_rj}, {e.ch, e.rj});
                chk(cyc == e.cyc, "b_latency", cyc, e.cyc);
            end
        end else begin
            chk(b_ch == 5'b00000 && !b_rj, "b_idle_zero", {b_ch, b_rj}, 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic a_send(input logic [9:0] d, input logic [2:0] ch, input logic rj);
        exp_t e;
        e.ch  = {2'b00, ch};
        e.rj  = rj;
        e.cyc = cyc + 2;
        a_data  = d;
        a_valid = 1'b1;
        qa.push_back(e);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
    endtask

    task automatic b_send(input logic [9:0] d, input logic [4:0] ch, input logic rj);
        exp_t e;
        e.ch  = ch;
        e.rj  = rj;
        e.cyc = cyc + 2;
        b_data  = d;
        b_valid = 1'b1;
        qb.push_back(e);
        @(posedge clk);
        #1;
        b_valid = 1'b0;
    endtask

    task automatic a_read(input logic [1:0] idx, input logic [15:0] exp, input string nm);
        a_rd_idx = idx;
        @(posedge clk);
        #1;
        chk(a_rd_data == exp, nm, a_rd_data, exp);
    endtask

    task automatic b_read(input logic [2:0] idx, input logic [3:0] exp, input string nm);
        b_rd_idx = idx;
        @(posedge clk);
        #1;
        chk(b_rd_data == exp, nm, b_rd_data, exp);
    endtask

    task automatic b_wr(input logic [2:0] idx, input logic [9:0] val);
        b_thr_wr   = 1'b1;
        b_thr_idx  = idx;
        b_thr_data = val;
        @(posedge clk);
        #1;
        b_thr_wr = 1'b0;
    endtask

    // reference for B with boundaries 0,10,20,30,40,50
    task automatic exp_b(input int d, output logic [4:0] ch, output logic rj);
        int bin;
        if (d > 50) begin
            ch = 5'b00000;
            rj = 1'b1;
        end else begin
            bin = (d == 0) ? 0 : (d - 1) / 10;
            ch  = 5'b00001 << bin;
            rj  = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [4:0] ch;
        logic       rj;

        vecs[0] = '{d: 10'd240,  ch: 3'b001, rj: 1'b0};
        vecs[1] = '{d: 10'd340,  ch: 3'b001, rj: 1'b0};
        vecs[2] = '{d: 10'd341,  ch: 3'b010, rj: 1'b0};
        vecs[3] = '{d: 10'd400,  ch: 3'b010, rj: 1'b0};
        vecs[4] = '{d: 10'd450,  ch: 3'b100, rj: 1'b0};
        vecs[5] = '{d: 10'd239,  ch: 3'b000, rj: 1'b1};
        vecs[6] = '{d: 10'd451,  ch: 3'b000, rj: 1'b1};
        vecs[7] = '{d: 10'd0,    ch: 3'b000, rj: 1'b1};
        vecs[8] = '{d: 10'd1023, ch: 3'b000, rj: 1'b1};
        vecs[9] = '{d: 10'd401,  ch: 3'b100, rj: 1'b0};

        rst_a = 1'b0; rst_b = 1'b0;
        a_data = '0; a_valid = 1'b0; a_thr_wr = 1'b0; a_thr_idx = '0; a_thr_data = '0;
        a_clr = 1'b0; a_rd_idx = '0;
        b_data = '0; b_valid = 1'b0; b_thr_wr = 1'b0; b_thr_idx = '0; b_thr_data = '0;
        b_clr = 1'b0; b_rd_idx = '0;
        #1;
        rst_a = 1'b1; rst_b = 1'b1;
        #1;
        chk(a_ov == 1'b0 && a_ch == 3'b000 && a_rj == 1'b0, "a_reset_outputs", {a_ov, a_ch, a_rj}, 0);
        chk(a_rd_data == 16'd0, "a_reset_rd_data", a_rd_data, 0);
        chk(b_ov == 1'b0 && b_ch == 5'b00000 && b_rj == 1'b0, "b_reset_outputs", {b_ov, b_ch, b_rj}, 0);
        chk(b_rd_data == 4'd0, "b_reset_rd_data", b_rd_data, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        idle(1);

        // default boundaries, table of samples
        for (int i = 0; i < 10; i++) a_send(vecs[i].d, vecs[i].ch, vecs[i].rj);
        idle(4);
        a_read(2'd0, 16'd2, "a_tbl_cnt_bin0");
        a_read(2'd1, 16'd2, "a_tbl_cnt_bin1");
        a_read(2'd2, 16'd2, "a_tbl_cnt_bin2");
        a_read(2'd3, 16'd4, "a_tbl_cnt_reject");

        // clear then 1000 back-to-back samples into bin 0
        a_clr = 1'b1;
        idle(1);
        a_clr = 1'b0;
        for (int i = 0; i < 1000; i++) a_send(10'd300, 3'b001, 1'b0);
        idle(4);
        a_read(2'd0, 16'd1000, "a_burst_cnt_bin0");
        a_read(2'd1, 16'd0,    "a_burst_cnt_bin1");
        a_read(2'd2, 16'd0,    "a_burst_cnt_bin2");
        a_read(2'd3, 16'd0,    "a_burst_cnt_reject");

        // boundary 1 -> 300; the sample in the write cycle still sees 340
        a_thr_wr = 1'b1; a_thr_idx = 2'd1; a_thr_data = 10'd300;
        a_send(10'd320, 3'b001, 1'b0);
        a_thr_wr = 1'b0;
        a_send(10'd320, 3'b010, 1'b0);
        a_send(10'd300, 3'b001, 1'b0);
        a_send(10'd301, 3'b010, 1'b0);
        idle(4);

        // reset with samples in flight: nothing emerges, state returns to init
        a_data = 10'd320; a_valid = 1'b1;
        @(posedge clk);
        #1;
        a_data = 10'd330;
        #2;
        rst_a = 1'b1; a_valid = 1'b0;
        #1;
        chk(a_ov == 1'b0, "a_midrst_ov", a_ov, 0);
        @(posedge clk);
        #1;
        chk(a_ov == 1'b0, "a_midrst_ov_hold", a_ov, 0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        idle(3);
        a_read(2'd0, 16'd0, "a_midrst_cnt_bin0");
        a_read(2'd1, 16'd0, "a_midrst_cnt_bin1");
        a_read(2'd2, 16'd0, "a_midrst_cnt_bin2");
        a_read(2'd3, 16'd0, "a_midrst_cnt_reject");
        a_send(10'd320, 3'b001, 1'b0);
        a_send(10'd341, 3'b010, 1'b0);
        a_send(10'd239, 3'b000, 1'b1);
        idle(4);

        // B: load 0,10..50; out-of-range indices must be ignored
        b_wr(3'd1, 10'd10);
        b_wr(3'd2, 10'd20);
        b_wr(3'd3, 10'd30);
        b_wr(3'd4, 10'd40);
        b_wr(3'd5, 10'd50);
        b_wr(3'd6, 10'd5);
        b_wr(3'd7, 10'd3);
        idle(1);
        for (int d = 0; d <= 60; d++) begin
            exp_b(d, ch, rj);
            b_send(10'(d), ch, rj);
        end
        idle(4);
        b_read(3'd0, 4'd11, "b_sweep_cnt_bin0");
        b_read(3'd1, 4'd10, "b_sweep_cnt_bin1");
        b_read(3'd2, 4'd10, "b_sweep_cnt_bin2");
        b_read(3'd3, 4'd10, "b_sweep_cnt_bin3");
        b_read(3'd4, 4'd10, "b_sweep_cnt_bin4");
        b_read(3'd5, 4'd10, "b_sweep_cnt_reject");
        b_read(3'd6, 4'd0,  "b_rd_idx6_zero");
        b_read(3'd7, 4'd0,  "b_rd_idx7_zero");

        // saturation at 15
        b_clr = 1'b1;
        idle(1);
        b_clr = 1'b0;
        for (int i = 0; i < 20; i++) b_send(10'd25, 5'b00100, 1'b0);
        idle(4);
        b_read(3'd2, 4'd15, "b_sat_bin2");
        b_read(3'd0, 4'd0,  "b_sat_bin0");

        // clear lands on the same edge as a bin-2 increment: clear wins
        b_send(10'd25, 5'b00100, 1'b0);
        b_clr = 1'b1;
        idle(1);
        b_clr = 1'b0;
        idle(3);
        b_read(3'd2, 4'd0, "b_clear_beats_inc");
        b_send(10'd25, 5'b00100, 1'b0);
        idle(4);
        b_read(3'd2, 4'd1, "b_count_after_clear");

        idle(2);
        chk(qa.size() == 0, "a_scoreboard_empty", qa.size(), 0);
        chk(qb.size() == 0, "b_scoreboard_empty", qb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
